// File: rtl/relu.sv
// relu: registered ReLU with upper clip over LANES packed signed elements; RELU_LEAKY_EN selects leaky ReLU
module relu #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 1,
  parameter int CLIP_MAX   = 127,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] in,
  input  logic                    en,
  output logic [LANES*DATA_W-1:0] out,
  output logic                    out_en
);
  localparam logic signed [DATA_W-1:0] CLIP = DATA_W'(CLIP_MAX);
  if (CLIP_MAX < 0 || CLIP_MAX > 2**(DATA_W-1)-1 || LEAK_SHIFT < 1 || LEAK_SHIFT > DATA_W-1) begin : g_bad_param
    $error("relu: CLIP_MAX or LEAK_SHIFT out of range");
  end
  logic [LANES*DATA_W-1:0] act;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] x;
    assign x = in[g*DATA_W +: DATA_W];
`ifdef RELU_LEAKY_EN
    assign act[g*DATA_W +: DATA_W] = x[DATA_W-1] ? x >>> LEAK_SHIFT : (x > CLIP ? CLIP : x);
`else
    assign act[g*DATA_W +: DATA_W] = x[DATA_W-1] ? '0 : (x > CLIP ? CLIP : x);
`endif
  end
  // output register: capture activated lanes on enable, hold otherwise; valid follows en by one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out    <= '0;
      out_en <= 1'b0;
    end else begin
      out_en <= en;
      if (en) out <= act;
    end
  end
endmodule

// File: tb/tb_relu.sv
// tb_relu: directed self-checking bench for relu (default, clipped and 4-lane instances)
module tb_relu;
  logic        clk = 0;
  logic        reset = 1;
  logic        en = 0;
  logic [7:0]  in = '0, in_c = '0;
  logic [31:0] in_w = '0;
  logic [7:0]  out, out_c;
  logic [31:0] out_w;
  logic        out_en, out_en_c, out_en_w;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  relu dut (.clk(clk), .reset(reset), .in(in), .en(en), .out(out), .out_en(out_en));
  relu #(.CLIP_MAX(6)) dut_c (.clk(clk), .reset(reset), .in(in_c), .en(en), .out(out_c), .out_en(out_en_c));
  relu #(.LANES(4)) dut_w (.clk(clk), .reset(reset), .in(in_w), .en(en), .out(out_w), .out_en(out_en_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef RELU_LEAKY_EN
  logic [7:0] s_exp [5] = '{8'h05, 8'hF0, 8'h7F, 8'hFF, 8'h00};
  logic [7:0] c_exp [4] = '{8'h03, 8'h06, 8'h06, 8'hFE};
  logic [7:0] l_exp [4] = '{8'hFE, 8'hFF, 8'hF0, 8'h20};
  logic [31:0] w_exp = 32'hF0_7F_01_FF;
`else
  logic [7:0] s_exp [5] = '{8'h05, 8'h00, 8'h7F, 8'h00, 8'h00};
  logic [7:0] c_exp [4] = '{8'h03, 8'h06, 8'h06, 8'h00};
  logic [7:0] l_exp [4] = '{8'h00, 8'h00, 8'h00, 8'h20};
  logic [31:0] w_exp = 32'h00_7F_01_00;
`endif
  logic [7:0] s_in [5] = '{8'h05, 8'h80, 8'h7F, 8'hFF, 8'h00};
  logic [7:0] c_in [4] = '{8'h03, 8'h06, 8'h10, 8'hF0};
  logic [7:0] l_in [4] = '{8'hF0, 8'hFF, 8'h80, 8'h20};

  initial begin
    #2;
    reset = 0;
    en = 1;
    in = 8'h55;
    #1;
    check("async_reset_out", out, 0);
    check("async_reset_en", out_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("reset_hold_out", out, 0);
      check("reset_hold_en", out_en, 0);
    end
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      in = s_in[i];
      tick;
      check("stream_out", out, s_exp[i]);
      check("stream_en", out_en, 1);
    end
    for (int i = 0; i < 10; i++) begin
      in = 8'h10 + 8'(i);
      tick;
      check("en_run_out", out, 8'h10 + 8'(i));
      check("en_run_en", out_en, 1);
    end
    en = 0;
    for (int i = 0; i < 10; i++) begin
      in = (i == 4) ? 'x : 8'h60 + 8'(i);
      tick;
      check("frozen_out", out, 8'h19);
      check("frozen_en", out_en, 0);
    end
    en = 1;
    for (int i = 0; i < 4; i++) begin
      in_c = c_in[i];
      tick;
      check("clip_out", out_c, c_exp[i]);
      check("clip_en", out_en_c, 1);
    end
    in_w = 32'h80_7F_01_FE;
    tick;
    check("lanes_out", out_w, w_exp);
    check("lanes_en", out_en_w, 1);
    for (int i = 0; i < 4; i++) begin
      in = l_in[i];
      tick;
      check("leak_out", out, l_exp[i]);
    end
    for (int i = 0; i < 6; i++) begin
      en = i[0];
      in = 8'h30 + 8'(i);
      tick;
      check("toggle_en", out_en, 32'(i[0]));
      check("toggle_out", out, i[0] ? 8'h30 + 8'(i) : (i == 0 ? 8'h20 : 8'h30 + 8'(i - 1)));
    end
    en = 1;
    in = 8'h44;
    tick;
    check("pre_reset_out", out, 8'h44);
    in = 8'h22;
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    check("mid_reset_out", out, 0);
    check("mid_reset_en", out_en, 0);
    check("mid_reset_lanes", out_w, 0);
    @(posedge clk);
    #1;
    reset = 1;
    in = 8'h11;
    tick;
    check("post_reset_out", out, 8'h11);
    check("post_reset_en", out_en, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
